mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter_arb_select.sv | 22 ++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state and line-owner encodings.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OWN_IR,
    OWN_D
  } owner_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: I-cache refill port, D-cache line port and
// the single-beat main-memory port. slave = arbiter side, master = environment.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              ir_req;
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W-1:0] ir_rdata;
  logic              ir_rvalid;
  logic              ir_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_wnext;
  logic              d_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport slave (
    input  ir_req, ir_addr,
    output ir_rdata, ir_rvalid, ir_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_rvalid, d_wnext, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata, mem_rvalid
  );

  modport master (
    output ir_req, ir_addr,
    input  ir_rdata, ir_rvalid, ir_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_rvalid, d_wnext, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/mem_arbiter_arb_select.sv
// Two-requester grant select: a lone requester wins, a tie goes to the
// requester that was not served last.
module arb_select
  import mem_arbiter_pkg::*;
(
  input  logic   ir_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output owner_t owner
);

  // Resolve the grant for the current IDLE cycle.
  always_comb begin
    owner = OWN_D;
    if (ir_req && d_req) begin
      owner = (last_owner == OWN_D) ? OWN_IR : OWN_D;
    end else if (ir_req) begin
      owner = OWN_IR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-beat main-memory port between an I-cache
// refill requester and a D-cache line requester, one cache line per grant.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie-break; when
// undefined the D requester always wins ties and no pointer register exists).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  localparam int unsigned BEAT_W     = $clog2(BURST_LEN);
  localparam int unsigned LINE_BYTES = BURST_LEN * WORD_BYTES;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  owner_t            grant;
  owner_t            last_owner;
  logic [DATA_W-1:0] rdata_fwd;
  logic              any_req;

  assign any_req   = bus.ir_req || bus.d_req;
  assign rdata_fwd = bus.mem_rdata;

  arb_select u_arb_select (
    .ir_req     (bus.ir_req),
    .d_req      (bus.d_req),
    .last_owner (last_owner),
    .owner      (grant)
  );

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_q;

  // Remember the most recent grant so the next tie goes to the other side.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= OWN_D;
    end else if (state_q == IDLE && any_req) begin
      last_q <= grant;
    end
  end

  assign last_owner = last_q;
`else
  // A constant "IR served last" makes arb_select resolve every tie to D.
  assign last_owner = OWN_IR;
`endif

  // FSM and line-context registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= OWN_D;
      base_q  <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE, so a requester
  // dropping req mid-burst cannot disturb the line in progress.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    we_d    = we_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant;
          base_d  = ((grant == OWN_D) ? bus.d_addr : bus.ir_addr) & LINE_MASK;
          we_d    = (grant == OWN_D) && bus.d_we;
          beat_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ready) begin
          if (!we_q) begin
            state_d = WAIT;
          end else if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore-style bus outputs plus combinational read-data forwarding.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.d_wnext   = 1'b0;
    bus.ir_rdata  = '0;
    bus.ir_rvalid = 1'b0;
    bus.ir_done   = 1'b0;
    bus.d_rdata   = '0;
    bus.d_rvalid  = 1'b0;
    bus.d_done    = 1'b0;
    if (state_q == REQ) begin
      bus.mem_req  = 1'b1;
      bus.mem_we   = we_q;
      bus.mem_addr = base_q + (ADDR_W'(beat_q) << WORD_SHIFT);
      if (we_q) begin
        bus.mem_wdata = bus.d_wdata;
        bus.d_wnext   = bus.mem_ready;
      end
    end
    if (state_q == WAIT && bus.mem_rvalid) begin
      if (owner_q == OWN_IR) begin
        bus.ir_rvalid = 1'b1;
        bus.ir_rdata  = rdata_fwd;
      end else begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = rdata_fwd;
      end
    end
    if (state_q == DONE) begin
      bus.ir_done = (owner_q == OWN_IR);
      bus.d_done  = (owner_q == OWN_D);
    end
  end

endmodule
